// File: rtl/reset_seq_pkg.sv
// Shared state encodings and sizing helpers for the reset release sequencer.
package reset_seq_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DELAY    = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    DELAY    = ST_DELAY,
    WAIT_ACK = ST_WAIT_ACK,
    DONE     = ST_DONE,
    ERROR    = ST_ERROR
  } seq_state_e;

  // One counter serves both the settle delay and the ready timeout, so it is
  // sized for the larger of the two.
  function automatic int cnt_width(input int delay_cycles, input int timeout_cycles);
    int max_val;
    max_val = (delay_cycles > timeout_cycles) ? delay_cycles : timeout_cycles;
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Up-counter with a registered terminal-count flag. The flag reflects
// (count == term) for the count it is registered alongside, so the caller
// must present the terminal value belonging to the state being entered.
module reset_seq_timer #(
  parameter int CW = 4
) (
  input  logic          sync_clock_in,
  input  logic          reset_in,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] term,
  output logic          tc
);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Next count: clear wins over enable.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count + 1'b1;
    end
  end

  // Count and terminal-count flag registers.
  always_ff @(posedge sync_clock_in or posedge reset_in) begin
    if (reset_in) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= (count_next == term);
    end
  end

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases downstream reset domains one at a time in index order, with a
// settle delay before each release and a bounded wait for each ready ack.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | upstream reset asserted; all domains held in reset
// DELAY    | settling before releasing domain seq_index_out
// WAIT_ACK | domain released, waiting for its ready (with timeout)
// DONE     | every domain released and acknowledged; outputs frozen
// ERROR    | ready timeout; all domains back in reset until upstream cycles
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int DELAY_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   sync_clock_in,
  input  logic                   reset_in,
  input  logic                   reset_n_synced_in,
  input  logic [NUM_DOMAINS-1:0] domain_ready_in,
  output logic [NUM_DOMAINS-1:0] domain_reset_n_out,
  output logic                   seq_busy_out,
  output logic                   seq_done_out,
  output logic                   seq_error_out,
  output logic [IW-1:0]          seq_index_out
);

  localparam int            CW         = cnt_width(DELAY_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] DELAY_TC   = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_TC = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DOMAINS - 1);

  seq_state_e    state;
  seq_state_e    state_next;
  logic          tc;
  logic          ready_sel;
  logic          timeout_hit;
  logic          tmr_clear;
  logic          tmr_enable;
  logic [CW-1:0] tmr_term;

  assign ready_sel   = domain_ready_in[seq_index_out];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && tc;

  // Next-state decode; an upstream drop overrides everything.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = DELAY;
      DELAY:    if (tc) state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (ready_sel) begin
          state_next = (seq_index_out == LAST_IDX) ? DONE : DELAY;
        end else if (timeout_hit) begin
          state_next = ERROR;
        end
      end
      default:  state_next = state;
    endcase
    if (!reset_n_synced_in) begin
      state_next = IDLE;
    end
  end

  // Timer restarts on every state entry so it can never wrap; with the
  // timeout disabled it simply stays parked at zero while waiting.
  always_comb begin
    tmr_clear  = (state_next != state) ||
                 !((state_next == DELAY) || (state_next == WAIT_ACK));
    tmr_enable = (state_next == DELAY) ||
                 ((state_next == WAIT_ACK) && (TIMEOUT_CYCLES != 0));
    tmr_term   = (state_next == WAIT_ACK) ? TIMEOUT_TC : DELAY_TC;
  end

  reset_seq_timer #(.CW(CW)) u_timer (
    .sync_clock_in (sync_clock_in),
    .reset_in      (reset_in),
    .clear         (tmr_clear),
    .enable        (tmr_enable),
    .term          (tmr_term),
    .tc            (tc)
  );

  // State and registered status/reset outputs.
  always_ff @(posedge sync_clock_in or posedge reset_in) begin
    if (reset_in) begin
      state              <= IDLE;
      domain_reset_n_out <= '0;
      seq_busy_out       <= 1'b0;
      seq_done_out       <= 1'b0;
      seq_error_out      <= 1'b0;
      seq_index_out      <= '0;
    end else begin
      state <= state_next;
      if (!reset_n_synced_in) begin
        domain_reset_n_out <= '0;
        seq_busy_out       <= 1'b0;
        seq_done_out       <= 1'b0;
        seq_error_out      <= 1'b0;
        seq_index_out      <= '0;
      end else begin
        case (state)
          IDLE: begin
            seq_busy_out  <= 1'b1;
            seq_index_out <= '0;
          end
          DELAY: begin
            if (tc) domain_reset_n_out[seq_index_out] <= 1'b1;
          end
          WAIT_ACK: begin
            if (ready_sel) begin
              if (seq_index_out == LAST_IDX) begin
                seq_done_out <= 1'b1;
                seq_busy_out <= 1'b0;
              end else begin
                seq_index_out <= seq_index_out + 1'b1;
              end
            end else if (timeout_hit) begin
              domain_reset_n_out <= '0;
              seq_error_out      <= 1'b1;
              seq_busy_out       <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer (3 domains, delay 4, timeout 8).
// Each run draws a ready latency per domain; the reference model turns those
// latencies into release/ack/end edge numbers and derives expected outputs
// at every edge from that timeline.
module tb_reset_release_sequencer;

  localparam int N   = 3;
  localparam int D   = 4;
  localparam int T   = 8;
  localparam int BIG = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         up;
  logic [N-1:0] rdy;
  logic [N-1:0] dom;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   idx;

  int tests = 0;
  int fails = 0;

  int lat[N];
  int rel[N];
  int ack[N];
  int end_edge;
  bit err_run;

  always #5 clk = ~clk;

  reset_release_sequencer #(
    .NUM_DOMAINS    (N),
    .DELAY_CYCLES   (D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .sync_clock_in      (clk),
    .reset_in           (rst),
    .reset_n_synced_in  (up),
    .domain_ready_in    (rdy),
    .domain_reset_n_out (dom),
    .seq_busy_out       (busy),
    .seq_done_out       (done),
    .seq_error_out      (err),
    .seq_index_out      (idx)
  );

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // Timeline from latencies (edges counted from E0 = 0).
  task automatic plan();
    int t;
    t = D;
    err_run = 1'b0;
    end_edge = BIG;
    for (int k = 0; k < N; k++) begin
      rel[k] = BIG;
      ack[k] = BIG;
    end
    for (int k = 0; k < N; k++) begin
      rel[k] = t;
      if (lat[k] <= T) begin
        ack[k] = t + lat[k];
        t = ack[k] + D;
      end else begin
        err_run = 1'b1;
        end_edge = t + T;
        break;
      end
    end
    if (!err_run) end_edge = ack[N-1];
  endtask

  // Only the domain currently awaited gets a controlled ready; all other
  // bits are noise the design must ignore.
  task automatic drive_ready(input int m);
    int lim;
    for (int k = 0; k < N; k++) begin
      lim = (lat[k] <= T) ? ack[k] : end_edge;
      if (m > rel[k] && m <= lim) rdy[k] = (lat[k] <= T) && (m >= ack[k]);
      else                       rdy[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_edge(input int n, input int abort_at);
    logic [N-1:0] e_dom;
    int e_busy, e_done, e_err, e_idx, cnt;
    e_dom = '0;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      e_dom[k] = (n >= rel[k]) && !(err_run && n >= end_edge);
      if (ack[k] <= n) cnt++;
    end
    e_busy = (n < end_edge) ? 1 : 0;
    e_done = (!err_run && n >= end_edge) ? 1 : 0;
    e_err  = (err_run && n >= end_edge) ? 1 : 0;
    e_idx  = (cnt > N - 1) ? N - 1 : cnt;
    if (abort_at >= 0 && n >= abort_at) begin
      e_dom = '0; e_busy = 0; e_done = 0; e_err = 0; e_idx = 0;
    end
    chk("dom",  n, 32'(dom),  32'(e_dom));
    chk("busy", n, 32'(busy), e_busy);
    chk("done", n, 32'(done), e_done);
    chk("err",  n, 32'(err),  e_err);
    chk("idx",  n, 32'(idx),  e_idx);
  endtask

  task automatic check_clear(input string tag);
    chk({tag, "_dom"},  0, 32'(dom),  0);
    chk({tag, "_busy"}, 0, 32'(busy), 0);
    chk({tag, "_done"}, 0, 32'(done), 0);
    chk({tag, "_err"},  0, 32'(err),  0);
    chk({tag, "_idx"},  0, 32'(idx),  0);
  endtask

  // One sequence from IDLE; abort_at < 0 means upstream stays high.
  task automatic run_seq(input int abort_at);
    int last;
    plan();
    @(negedge clk);
    up  = 1'b1;
    rdy = N'($urandom);
    last = (abort_at >= 0) ? abort_at + 2 : end_edge + 3;
    for (int n = 0; n <= last && n < 60; n++) begin
      @(negedge clk);
      check_edge(n, abort_at);
      drive_ready(n + 1);
      if (abort_at >= 0 && n + 1 >= abort_at) up = 1'b0;
    end
    up = 1'b0;
    @(negedge clk);
    check_clear("drop");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst = 1'b1;
    up  = 1'b0;
    rdy = '0;
    repeat (3) @(negedge clk);
    check_clear("rst");
    rst = 1'b0;
    @(negedge clk);
    check_clear("idle");

    // nominal: releases at E4, E9, E14, done at E15
    lat = '{1, 1, 1};  run_seq(-1);
    // domain 1 never ready: error at E9+8
    lat = '{1, 99, 1}; run_seq(-1);
    // ready lands on the timeout edge itself
    lat = '{8, 1, 8};  run_seq(-1);
    // upstream drop during domain 1 WAIT_ACK, then full restart
    lat = '{1, 5, 1};  run_seq(11);
    lat = '{1, 1, 1};  run_seq(-1);

    repeat (20) begin
      for (int k = 0; k < N; k++) lat[k] = $urandom_range(1, 10);
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
      run_seq(a);
    end

    // async reset in the middle of domain 1's DELAY phase
    @(negedge clk);
    up  = 1'b1;
    rdy = '0;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      rdy = dom;
    end
    chk("arst_pre_dom",  7, 32'(dom),  1);
    chk("arst_pre_busy", 7, 32'(busy), 1);
    #2 rst = 1'b1;
    #1 check_clear("arst");
    up = 1'b0;
    @(negedge clk);
    check_clear("arst_hold");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
